// File: rtl/atan2_pkg.sv
// Shared constants for the orientation-bin sequencer: tangent thresholds, bin
// anchors, FSM state encoding and the quadrant fold.
package atan2_pkg;

  localparam int N_THERMO = 25;
  localparam int BIN_90   = 24;
  localparam int BIN_180  = 48;
  localparam int BIN_360  = 96;
  localparam int LUT_W    = 28;

  // round(tan(k*3.75deg) * 2^12); the last entry stands in for tan(90deg) and
  // exceeds any (ay << 12) so that bit 24 is set whenever ax != 0.
  localparam logic [LUT_W-1:0] TAN_LUT [0:N_THERMO-1] = '{
    28'd0,     28'd268,   28'd539,   28'd815,   28'd1098,
    28'd1390,  28'd1697,  28'd2020,  28'd2365,  28'd2737,
    28'd3143,  28'd3592,  28'd4096,  28'd4671,  28'd5338,
    28'd6130,  28'd7094,  28'd8306,  28'd9889,  28'd12066,
    28'd15286, 28'd20592, 28'd31112, 28'd62493, 28'd268435455
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CMP,
    ST_DECODE,
    ST_OUT
  } state_e;

  function automatic logic [6:0] fold_bin(input logic [1:0] quad, input logic [4:0] idx);
    logic [6:0] i7;
    i7 = {2'b00, idx};
    case (quad)
      2'd0:    fold_bin = i7;
      2'd1:    fold_bin = 7'(BIN_180) - i7;
      2'd2:    fold_bin = 7'(BIN_180) + i7;
      default: fold_bin = (i7 == 7'd0) ? 7'd0 : 7'(BIN_360) - i7;
    endcase
  endfunction

endpackage

// File: rtl/Atan2_Decoder.sv
// Thermometer-to-index decoder: a code with ones on [WIDTH-1:k] places the angle
// between LUT entries k-1 and k; all-ones gives 0/0, all-zeros gives top/top.
module Atan2_Decoder #(
  parameter int WIDTH       = 25,
  parameter int WIDTH_INDEX = 5
) (
  input  logic [WIDTH-1:0]       thermo_i,
  output logic [WIDTH_INDEX-1:0] index1_o,
  output logic [WIDTH_INDEX-1:0] index2_o,
  output logic                   legal_o
);

  always_comb begin
    index1_o = 'x;
    index2_o = 'x;
    legal_o  = 1'b0;
    if (thermo_i == '0) begin
      index1_o = WIDTH_INDEX'(WIDTH - 1);
      index2_o = WIDTH_INDEX'(WIDTH - 1);
      legal_o  = 1'b1;
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (thermo_i == ({WIDTH{1'b1}} << k)) begin
        index1_o = WIDTH_INDEX'((k == 0) ? 0 : k - 1);
        index2_o = WIDTH_INDEX'(k);
        legal_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/atan2_orient_seq.sv
// ORB orientation sequencer: builds the atan2 thermometer code one shared-multiplier
// compare per cycle, decodes it and folds the index by quadrant into a 0..95 bin.
//
// state     | meaning
// ST_IDLE   | ready; latch moments on in_valid
// ST_LOAD   | take magnitudes and quadrant; zero vector bypasses to decode
// ST_CMP    | one threshold compare per cycle, exit on first set bit
// ST_DECODE | register decoder indices and exact flag
// ST_OUT    | register folded bin, hold result until out_ready
module atan2_orient_seq
  import atan2_pkg::*;
#(
  parameter int WIDTH_M     = 16,
  parameter int FRAC        = 12,
  parameter int WIDTH_INDEX = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_M-1:0] m10,
  input  logic signed [WIDTH_M-1:0] m01,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_INDEX-1:0]    out_index1,
  output logic [WIDTH_INDEX-1:0]    out_index2,
  output logic [1:0]                out_quadrant,
  output logic                      out_exact,
  output logic [6:0]                out_angle_bin
);

  localparam int CMP_W = LUT_W + WIDTH_M;

  state_e                 state_q, state_d;
  logic [WIDTH_M-1:0]     m10_q, m10_d, m01_q, m01_d;
  logic [WIDTH_M-1:0]     ax_q, ax_d, ay_q, ay_d;
  logic [1:0]             quad_q, quad_d;
  logic [N_THERMO-1:0]    thermo_q, thermo_d;
  logic [WIDTH_INDEX-1:0] j_q, j_d, idx1_q, idx1_d, idx2_q, idx2_d;
  logic                   exact_q, exact_d, valid_q, valid_d;
  logic [6:0]             bin_q, bin_d;

  logic [WIDTH_INDEX-1:0] dec_idx1, dec_idx2;
  logic                   dec_legal;
  logic [WIDTH_M-1:0]     abs_x, abs_y;
  logic [1:0]             quad_in;
  logic [CMP_W-1:0]       lhs, rhs;
  logic                   cmp_bit;

  // Unsigned magnitude: the most negative input lands on 2^(WIDTH_M-1) exactly.
  assign abs_x   = m10_q[WIDTH_M-1] ? (~m10_q + WIDTH_M'(1)) : m10_q;
  assign abs_y   = m01_q[WIDTH_M-1] ? (~m01_q + WIDTH_M'(1)) : m01_q;
  assign quad_in = {m01_q[WIDTH_M-1], m10_q[WIDTH_M-1] ^ m01_q[WIDTH_M-1]};

  assign lhs     = CMP_W'(ay_q) << FRAC;
  assign rhs     = CMP_W'(TAN_LUT[j_q]) * CMP_W'(ax_q);
  assign cmp_bit = lhs < rhs;

  Atan2_Decoder #(
    .WIDTH       (N_THERMO),
    .WIDTH_INDEX (WIDTH_INDEX)
  ) u_dec (
    .thermo_i (thermo_q),
    .index1_o (dec_idx1),
    .index2_o (dec_idx2),
    .legal_o  (dec_legal)
  );

  always_comb begin
    state_d  = state_q;
    m10_d    = m10_q;
    m01_d    = m01_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    quad_d   = quad_q;
    thermo_d = thermo_q;
    j_d      = j_q;
    idx1_d   = idx1_q;
    idx2_d   = idx2_q;
    exact_d  = exact_q;
    valid_d  = valid_q;
    bin_d    = bin_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m10_d   = m10;
          m01_d   = m01;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ax_d   = abs_x;
        ay_d   = abs_y;
        quad_d = quad_in;
        j_d    = '0;
        if (abs_x == '0 && abs_y == '0) begin
          thermo_d = '1;
          state_d  = ST_DECODE;
        end else begin
          thermo_d = '0;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        if (cmp_bit) begin
          thermo_d = thermo_q | ({N_THERMO{1'b1}} << j_q);
          state_d  = ST_DECODE;
        end else begin
          thermo_d[j_q] = 1'b0;
          if (j_q == WIDTH_INDEX'(N_THERMO - 1)) state_d = ST_DECODE;
          else                                   j_d     = j_q + WIDTH_INDEX'(1);
        end
      end
      ST_DECODE: begin
        idx1_d  = dec_idx1;
        idx2_d  = dec_idx2;
        exact_d = (dec_idx1 == dec_idx2);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          bin_d   = fold_bin(quad_q, 5'(idx1_q));
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      m10_q    <= '0;
      m01_q    <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      quad_q   <= '0;
      thermo_q <= '0;
      j_q      <= '0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      exact_q  <= 1'b0;
      valid_q  <= 1'b0;
      bin_q    <= '0;
    end else begin
      state_q  <= state_d;
      m10_q    <= m10_d;
      m01_q    <= m01_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      quad_q   <= quad_d;
      thermo_q <= thermo_d;
      j_q      <= j_d;
      idx1_q   <= idx1_d;
      idx2_q   <= idx2_d;
      exact_q  <= exact_d;
      valid_q  <= valid_d;
      bin_q    <= bin_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = valid_q;
  assign out_index1    = idx1_q;
  assign out_index2    = idx2_q;
  assign out_quadrant  = quad_q;
  assign out_exact     = exact_q;
  assign out_angle_bin = bin_q;

  a_dec_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_DECODE) |-> dec_legal);
  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_OUT) |-> (int'(idx1_q) <= BIN_90));

endmodule

// File: tb/tb_atan2_orient_seq.sv
// Scoreboard bench for atan2_orient_seq: directed moment pairs with hand-derived
// indices, bins and latencies; a negedge monitor checks every result.
module tb_atan2_orient_seq;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] m10;
  logic signed [15:0] m01;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_index1;
  logic [4:0]        out_index2;
  logic [1:0]        out_quadrant;
  logic              out_exact;
  logic [6:0]        out_angle_bin;

  atan2_orient_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .m10           (m10),
    .m01           (m01),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index1    (out_index1),
    .out_index2    (out_index2),
    .out_quadrant  (out_quadrant),
    .out_exact     (out_exact),
    .out_angle_bin (out_angle_bin)
  );

  typedef struct {
    int x; int y; int i1; int i2; int q; int ex; int bin; int lat;
  } vec_t;

  vec_t exp_q[$];
  int   acc_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency and fields at out_valid rise, bin again at the handshake.
  initial begin
    logic prev_v;
    vec_t e;
    int   lat;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_q.delete();
        prev_v = 1'b0;
        continue;
      end
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", int'(out_valid), 0);
        end else begin
          e   = exp_q[0];
          lat = (acc_q.size() > 0) ? cyc - acc_q.pop_front() : -1;
          check("latency",   lat,                 e.lat);
          check("index1",    int'(out_index1),    e.i1);
          check("index2",    int'(out_index2),    e.i2);
          check("quadrant",  int'(out_quadrant),  e.q);
          check("exact",     int'(out_exact),     e.ex);
          check("angle_bin", int'(out_angle_bin), e.bin);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bin_at_handshake", int'(out_angle_bin), e.bin);
      end
      prev_v = out_valid;
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    exp_q.push_back(v);
    m10      = 16'(v.x);
    m01      = 16'(v.y);
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    #2;
  endtask

  vec_t vecs[8] = '{
    '{100,    0,     0,  1,  0, 0, 0,  5},
    '{0,      50,    24, 24, 0, 1, 24, 28},
    '{-100,   0,     0,  1,  1, 0, 48, 5},
    '{100,    -1,    0,  1,  3, 0, 0,  5},
    '{0,      0,     0,  0,  0, 1, 0,  3},
    '{-32768, 32767, 11, 12, 1, 0, 37, 16},
    '{1,      -32768,23, 24, 3, 0, 73, 28},
    '{0,      -7,    24, 24, 3, 1, 72, 28}
  };
  vec_t va     = '{100,  100, 12, 13, 0, 0, 12, 17};
  vec_t vb     = '{-50,  -50, 12, 13, 2, 0, 60, 17};
  vec_t vabort = '{0,    50,  24, 24, 0, 1, 24, 28};
  vec_t vpost  = '{30,   -40, 14, 15, 3, 0, 82, 19};

  initial begin
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    m10       = '0;
    m01       = '0;
    out_ready = 1'b1;
    #3;
    check("reset_in_ready",  int'(in_ready),      1);
    check("reset_out_valid", int'(out_valid),     0);
    check("reset_index1",    int'(out_index1),    0);
    check("reset_index2",    int'(out_index2),    0);
    check("reset_bin",       int'(out_angle_bin), 0);
    check("reset_exact",     int'(out_exact),     0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      send(vecs[k]);
      wait_drain();
    end

    // Stall in OUT with a new request pending; it must wait for the handshake.
    out_ready = 1'b0;
    send(va);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("stall_valid_timeout", 0, 1);
    @(posedge clk);
    #2;
    exp_q.push_back(vb);
    m10      = 16'(vb.x);
    m01      = 16'(vb.y);
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("stall_in_ready",  int'(in_ready),      0);
      check("stall_valid",     int'(out_valid),     1);
      check("stall_bin",       int'(out_angle_bin), va.bin);
      check("stall_index1",    int'(out_index1),    va.i1);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("stall_accept_timeout", 0, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    wait_drain();

    // Reset while comparing j=7 of a 25-compare transaction.
    send(vabort);
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_in_ready",  int'(in_ready),  1);
    check("abort_out_valid", int'(out_valid), 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_valid", int'(out_valid), 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send(vpost);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
